// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar crosspoint buffer.
//   - default widths/depths used as parameter defaults by crossbar_point_pkt
//   - ingress admission and egress FSM state encodings
//   - helper to size the beat/length counters
package xbar_pkg;

  localparam int XBAR_DEST_W     = 3;
  localparam int XBAR_USER_W     = 2;
  localparam int XBAR_USER_MATCH = 1;
  localparam int XBAR_DATA_W     = 64;
  localparam int XBAR_DATA_DEPTH = 256;
  localparam int XBAR_PKT_DEPTH  = 32;
  localparam int XBAR_MAX_BEATS  = 64;

  typedef enum logic [1:0] {
    EG_IDLE,
    EG_REQ,
    EG_LOAD,
    EG_SEND
  } eg_state_t;

  typedef enum logic [1:0] {
    IN_SOP,
    IN_STORE,
    IN_DROP,
    IN_SKIP
  } in_state_t;

  // One extra bit so that a count equal to max_beats is representable.
  function automatic int xbar_len_w(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/xbar_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst      clock, synchronous active-high reset (pointers/count cleared)
//   wr_en/wr_data push; ignored while full
//   rd_en         pop;  ignored while empty
//   rd_data       current head, valid whenever !empty
//   full/empty    status
//   count         occupancy, 0..DEPTH
// Push and pop in the same cycle are both serviced. DEPTH must be a power of 2.
module xbar_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  // Storage is not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/crossbar_point_pkt.sv
// Per-destination crosspoint buffer. Snoops the shared ingress AXIS bus, keeps
// whole packets addressed to P_DEST with class P_USER_MATCH, requests the
// output arbiter and streams one stored packet per grant.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   o_trans_req/i_trans_grant arbiter handshake (grant is a one-cycle pulse)
//   s_axis_rx_*               ingress snoop (no tready, cannot be stalled)
//   m_axis_tx_*               egress stream; tuser=1 marks a truncated packet
//   o_drop                    pulse when a matching packet is refused
//   o_stat_pkts/o_stat_drops  saturating counters
//
// Build option: define XBAR_PKT_STATS_EN to build the statistics counters;
// without it the counter ports are tied to zero.
//
// Egress FSM:
//   state   | meaning
//   EG_IDLE | no packet in flight; request when a descriptor is waiting
//   EG_REQ  | o_trans_req high, waiting for grant
//   EG_LOAD | pop descriptor, prime first beat
//   EG_SEND | stream beats under tready backpressure
// Ingress admission:
//   state    | meaning
//   IN_SOP   | next valid beat starts a packet
//   IN_STORE | admitted packet, beats written to data FIFO
//   IN_DROP  | matching packet refused; pulse o_drop on tlast
//   IN_SKIP  | unmatched packet or truncated tail; discard silently
module crossbar_point_pkt
  import xbar_pkg::*;
#(
  parameter int P_DEST       = 0,
  parameter int P_DATA_W     = XBAR_DATA_W,
  parameter int P_DEST_W     = XBAR_DEST_W,
  parameter int P_USER_W     = XBAR_USER_W,
  parameter int P_USER_MATCH = XBAR_USER_MATCH,
  parameter int P_DATA_DEPTH = XBAR_DATA_DEPTH,
  parameter int P_PKT_DEPTH  = XBAR_PKT_DEPTH,
  parameter int P_MAX_BEATS  = XBAR_MAX_BEATS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_trans_req,
  input  logic                  i_trans_grant,
  input  logic                  s_axis_rx_tvalid,
  input  logic [P_DATA_W-1:0]   s_axis_rx_tdata,
  input  logic                  s_axis_rx_tlast,
  input  logic [P_DATA_W/8-1:0] s_axis_rx_tkeep,
  input  logic [P_USER_W-1:0]   s_axis_rx_tuser,
  input  logic [P_DEST_W-1:0]   s_axis_rx_tdest,
  output logic                  m_axis_tx_tvalid,
  output logic [P_DATA_W-1:0]   m_axis_tx_tdata,
  output logic                  m_axis_tx_tlast,
  output logic [P_DATA_W/8-1:0] m_axis_tx_tkeep,
  output logic                  m_axis_tx_tuser,
  input  logic                  m_axis_tx_tready,
  output logic                  o_drop,
  output logic [31:0]           o_stat_pkts,
  output logic [31:0]           o_stat_drops
);

  localparam int KEEP_W = P_DATA_W / 8;
  localparam int CNT_W  = xbar_len_w(P_MAX_BEATS);
  localparam int DAW    = $clog2(P_DATA_DEPTH);
  localparam int PAW    = $clog2(P_PKT_DEPTH);

  localparam logic [CNT_W-1:0] MAX_LEN      = CNT_W'(P_MAX_BEATS);
  localparam logic [DAW:0]     DATA_DEPTH_C = (DAW+1)'(P_DATA_DEPTH);
  localparam logic [DAW:0]     ADMIT_FREE   = (DAW+1)'(P_MAX_BEATS);

  typedef struct packed {
    logic [CNT_W-1:0]  len;
    logic [KEEP_W-1:0] keep;
    logic              err;
  } desc_t;

  // ---------------- ingress input register ----------------
  logic                rx_valid;
  logic [P_DATA_W-1:0] rx_data;
  logic                rx_last;
  logic [KEEP_W-1:0]   rx_keep;
  logic [P_USER_W-1:0] rx_user;
  logic [P_DEST_W-1:0] rx_dest;

  always_ff @(posedge i_clk) begin
    rx_valid <= i_rst ? 1'b0 : s_axis_rx_tvalid;
    rx_data  <= s_axis_rx_tdata;
    rx_last  <= s_axis_rx_tlast;
    rx_keep  <= s_axis_rx_tkeep;
    rx_user  <= s_axis_rx_tuser;
    rx_dest  <= s_axis_rx_tdest;
  end

  // ---------------- FIFOs ----------------
  logic                data_wr;
  logic                data_rd;
  logic [P_DATA_W-1:0] data_head;
  logic                data_full;
  logic                data_empty;
  logic [DAW:0]        data_count;

  desc_t               desc_wr;
  desc_t               desc_head;
  logic                desc_push;
  logic                desc_rd;
  logic                desc_full;
  logic                desc_empty;
  logic [PAW:0]        desc_count;

  logic                ing_wr;

  assign data_wr = ing_wr && !data_full;

  xbar_sync_fifo #(.WIDTH(P_DATA_W), .DEPTH(P_DATA_DEPTH)) u_data_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (data_wr),
    .wr_data (rx_data),
    .rd_en   (data_rd),
    .rd_data (data_head),
    .full    (data_full),
    .empty   (data_empty),
    .count   (data_count)
  );

  xbar_sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(P_PKT_DEPTH)) u_desc_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (desc_push),
    .wr_data (desc_wr),
    .rd_en   (desc_rd),
    .rd_data (desc_head),
    .full    (desc_full),
    .empty   (desc_empty),
    .count   (desc_count)
  );

  // ---------------- ingress admission ----------------
  in_state_t        in_state;
  in_state_t        in_state_nx;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] in_cnt_nx;
  logic [CNT_W-1:0] in_cnt_inc;
  logic [DAW:0]     data_free;
  logic             rx_match;
  logic             rx_admit;
  logic             rx_store;
  logic             drop_nx;

  assign data_free  = DATA_DEPTH_C - data_count;
  assign rx_match   = (rx_dest == P_DEST_W'(P_DEST)) && (rx_user == P_USER_W'(P_USER_MATCH));
  // Admission reserves room for a worst-case packet so a stored packet can
  // never overflow the data FIFO mid-way.
  assign rx_admit   = rx_match && (data_free >= ADMIT_FREE) && !desc_full;
  assign rx_store   = rx_valid && ((in_state == IN_STORE) || ((in_state == IN_SOP) && rx_admit));
  assign in_cnt_inc = (in_state == IN_SOP) ? CNT_W'(1) : in_cnt + 1'b1;

  always_comb begin
    in_state_nx  = in_state;
    in_cnt_nx    = in_cnt;
    ing_wr       = 1'b0;
    desc_push    = 1'b0;
    drop_nx      = 1'b0;
    desc_wr.len  = in_cnt_inc;
    desc_wr.keep = rx_keep;
    desc_wr.err  = 1'b0;
    if (rx_store) begin
      ing_wr    = 1'b1;
      in_cnt_nx = in_cnt_inc;
      if (rx_last) begin
        desc_push   = 1'b1;
        in_state_nx = IN_SOP;
      end else if (in_cnt_inc == MAX_LEN) begin
        // Oversize: close the packet here, flag it and discard the tail.
        desc_push    = 1'b1;
        desc_wr.keep = '1;
        desc_wr.err  = 1'b1;
        in_state_nx  = IN_SKIP;
      end else begin
        in_state_nx = IN_STORE;
      end
    end else if (rx_valid) begin
      case (in_state)
        IN_SOP: begin
          if (rx_match) begin
            if (rx_last) drop_nx = 1'b1;
            else         in_state_nx = IN_DROP;
          end else if (!rx_last) begin
            in_state_nx = IN_SKIP;
          end
        end
        IN_DROP: begin
          if (rx_last) begin
            drop_nx     = 1'b1;
            in_state_nx = IN_SOP;
          end
        end
        IN_SKIP: begin
          if (rx_last) in_state_nx = IN_SOP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_state <= IN_SOP;
      in_cnt   <= '0;
      o_drop   <= 1'b0;
    end else begin
      in_state <= in_state_nx;
      in_cnt   <= in_cnt_nx;
      o_drop   <= drop_nx;
    end
  end

  // ---------------- egress FSM ----------------
  eg_state_t         eg_state;
  logic [CNT_W-1:0]  eg_len;
  logic [CNT_W-1:0]  eg_cnt;
  logic [KEEP_W-1:0] eg_keep;
  logic              eg_fire;
  logic              eg_next_last;

  assign eg_fire         = m_axis_tx_tvalid && m_axis_tx_tready;
  assign data_rd         = (eg_state == EG_SEND) && eg_fire && !data_empty;
  assign desc_rd         = (eg_state == EG_LOAD) && !desc_empty;
  assign eg_next_last    = (CNT_W'(eg_cnt + CNT_W'(2)) == eg_len);
  // Data is taken straight from the FWFT head, which only moves on a handshake.
  assign m_axis_tx_tdata = m_axis_tx_tvalid ? data_head : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      eg_state         <= EG_IDLE;
      o_trans_req      <= 1'b0;
      m_axis_tx_tvalid <= 1'b0;
      m_axis_tx_tlast  <= 1'b0;
      m_axis_tx_tkeep  <= '1;
      m_axis_tx_tuser  <= 1'b0;
      eg_len           <= '0;
      eg_cnt           <= '0;
      eg_keep          <= '1;
    end else begin
      unique case (eg_state)
        EG_IDLE: begin
          if (desc_count != '0) begin
            o_trans_req <= 1'b1;
            eg_state    <= EG_REQ;
          end
        end
        EG_REQ: begin
          if (i_trans_grant) begin
            o_trans_req <= 1'b0;
            eg_state    <= EG_LOAD;
          end
        end
        EG_LOAD: begin
          eg_len           <= desc_head.len;
          eg_keep          <= desc_head.keep;
          eg_cnt           <= '0;
          m_axis_tx_tvalid <= 1'b1;
          m_axis_tx_tlast  <= (desc_head.len == CNT_W'(1));
          m_axis_tx_tkeep  <= (desc_head.len == CNT_W'(1)) ? desc_head.keep : '1;
          m_axis_tx_tuser  <= desc_head.err;
          eg_state         <= EG_SEND;
        end
        EG_SEND: begin
          if (eg_fire) begin
            if (m_axis_tx_tlast) begin
              m_axis_tx_tvalid <= 1'b0;
              m_axis_tx_tlast  <= 1'b0;
              m_axis_tx_tkeep  <= '1;
              m_axis_tx_tuser  <= 1'b0;
              eg_state         <= EG_IDLE;
            end else begin
              eg_cnt          <= eg_cnt + 1'b1;
              m_axis_tx_tlast <= eg_next_last;
              m_axis_tx_tkeep <= eg_next_last ? eg_keep : '1;
            end
          end
        end
      endcase
    end
  end

  // ---------------- statistics ----------------
`ifdef XBAR_PKT_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_pkts  <= '0;
      o_stat_drops <= '0;
    end else begin
      if ((eg_state == EG_SEND) && eg_fire && m_axis_tx_tlast && (o_stat_pkts != '1))
        o_stat_pkts <= o_stat_pkts + 1'b1;
      if (o_drop && (o_stat_drops != '1))
        o_stat_drops <= o_stat_drops + 1'b1;
    end
  end
`else
  assign o_stat_pkts  = '0;
  assign o_stat_drops = '0;
`endif

endmodule

// File: tb/tb_crossbar_point_pkt.sv
// Directed and randomized bench for crossbar_point_pkt (default parameters).
// Expected egress is built from the packet-level rules: a matching packet is
// kept when at least 64 beat slots are free and fewer than 32 packets are
// stored, it is cut to 64 beats (error flag, full keep) when longer, and
// refused matching packets count as drops.
module tb_crossbar_point_pkt;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_trans_req;
  logic        i_trans_grant = 1'b0;
  logic        s_axis_rx_tvalid = 1'b0;
  logic [63:0] s_axis_rx_tdata = '0;
  logic        s_axis_rx_tlast = 1'b0;
  logic [7:0]  s_axis_rx_tkeep = '0;
  logic [1:0]  s_axis_rx_tuser = '0;
  logic [2:0]  s_axis_rx_tdest = '0;
  logic        m_axis_tx_tvalid;
  logic [63:0] m_axis_tx_tdata;
  logic        m_axis_tx_tlast;
  logic [7:0]  m_axis_tx_tkeep;
  logic        m_axis_tx_tuser;
  logic        m_axis_tx_tready = 1'b0;
  logic        o_drop;
  logic [31:0] o_stat_pkts;
  logic [31:0] o_stat_drops;

  crossbar_point_pkt dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .o_trans_req      (o_trans_req),
    .i_trans_grant    (i_trans_grant),
    .s_axis_rx_tvalid (s_axis_rx_tvalid),
    .s_axis_rx_tdata  (s_axis_rx_tdata),
    .s_axis_rx_tlast  (s_axis_rx_tlast),
    .s_axis_rx_tkeep  (s_axis_rx_tkeep),
    .s_axis_rx_tuser  (s_axis_rx_tuser),
    .s_axis_rx_tdest  (s_axis_rx_tdest),
    .m_axis_tx_tvalid (m_axis_tx_tvalid),
    .m_axis_tx_tdata  (m_axis_tx_tdata),
    .m_axis_tx_tlast  (m_axis_tx_tlast),
    .m_axis_tx_tkeep  (m_axis_tx_tkeep),
    .m_axis_tx_tuser  (m_axis_tx_tuser),
    .m_axis_tx_tready (m_axis_tx_tready),
    .o_drop           (o_drop),
    .o_stat_pkts      (o_stat_pkts),
    .o_stat_drops     (o_stat_drops)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [7:0]  keep;
    logic        user;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int st_beats = 0;      // beats the model believes are stored
  int st_pkts = 0;       // packets the model believes are stored
  int m_drops = 0;       // expected o_drop pulses since start
  int m_stat_pkts = 0;   // expected forwarded count since last reset
  int m_stat_drops = 0;  // expected drop count since last reset
  int drop_seen = 0;

  always @(negedge i_clk) if (o_drop) drop_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_pkt(input logic [2:0] dest, input logic [1:0] user,
                          input int len, input logic [7:0] keep_last);
    logic [63:0] d;
    beat_t       b;
    bit          match;
    bit          adm;
    int          n;
    match = (dest == 3'd0) && (user == 2'd1);
    adm   = match && ((256 - st_beats) >= 64) && (st_pkts < 32);
    if (match && !adm) begin
      m_drops++;
      m_stat_drops++;
    end
    n = (len > 64) ? 64 : len;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (adm && i < n) begin
        b.data = d;
        b.last = (i == n - 1);
        b.keep = (i == n - 1) ? ((len > 64) ? 8'hFF : keep_last) : 8'hFF;
        b.user = (len > 64);
        exp_q.push_back(b);
      end
      s_axis_rx_tvalid = 1'b1;
      s_axis_rx_tdata  = d;
      s_axis_rx_tlast  = (i == len - 1);
      s_axis_rx_tkeep  = (i == len - 1) ? keep_last : 8'($urandom);
      s_axis_rx_tuser  = user;
      s_axis_rx_tdest  = dest;
      @(negedge i_clk);
    end
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tlast  = 1'b0;
    if (adm) begin
      st_beats += n;
      st_pkts++;
    end
  endtask

  // mode 0: tready always 1, mode 1: toggles 1/0, other: random
  task automatic drain_pkt(input int mode, input string tag, output int first_valid);
    int    t;
    int    cyc;
    int    stab;
    bit    done;
    bit    hold;
    beat_t cur;
    beat_t prev;
    beat_t e;
    t = 0;
    while (!o_trans_req && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    check({tag, " req"}, o_trans_req, 1'b1);
    i_trans_grant = 1'b1;
    @(negedge i_clk);
    i_trans_grant = 1'b0;
    check({tag, " req_after_grant"}, o_trans_req, 1'b0);
    cyc = 0; stab = 0; done = 1'b0; hold = 1'b0; first_valid = -1;
    prev = '0;
    while (!done && cyc < 2000) begin
      cur.data = m_axis_tx_tdata;
      cur.last = m_axis_tx_tlast;
      cur.keep = m_axis_tx_tkeep;
      cur.user = m_axis_tx_tuser;
      if (hold && (cur != prev || !m_axis_tx_tvalid)) stab++;
      case (mode)
        0:       m_axis_tx_tready = 1'b1;
        1:       m_axis_tx_tready = (cyc % 2 == 0);
        default: m_axis_tx_tready = ($urandom_range(0, 3) != 0);
      endcase
      if (m_axis_tx_tvalid && first_valid < 0) first_valid = cyc;
      if (m_axis_tx_tvalid && m_axis_tx_tready) begin
        if (exp_q.size() == 0) begin
          check({tag, " beat_expected"}, exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check({tag, " beat"}, cur, e);
          st_beats--;
        end
        if (m_axis_tx_tlast) begin
          done = 1'b1;
          st_pkts--;
          m_stat_pkts++;
        end
      end
      hold = m_axis_tx_tvalid && !m_axis_tx_tready;
      prev = cur;
      @(negedge i_clk);
      cyc++;
    end
    m_axis_tx_tready = 1'b0;
    check({tag, " done"}, done, 1'b1);
    check({tag, " stable"}, stab, 0);
    check({tag, " gap"}, m_axis_tx_tvalid, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " req"},   o_trans_req, 1'b0);
    check({tag, " valid"}, m_axis_tx_tvalid, 1'b0);
    check({tag, " data"},  m_axis_tx_tdata, 64'h0);
    check({tag, " last"},  m_axis_tx_tlast, 1'b0);
    check({tag, " keep"},  m_axis_tx_tkeep, 8'hFF);
    check({tag, " user"},  m_axis_tx_tuser, 1'b0);
    check({tag, " drop"},  o_drop, 1'b0);
    check({tag, " stat_pkts"},  o_stat_pkts, 32'h0);
    check({tag, " stat_drops"}, o_stat_drops, 32'h0);
  endtask

  initial begin
    int fv;
    int t;
    bit seen;
    logic [2:0] dst;
    logic [1:0] usr;

    tick(4);
    i_rst = 1'b0;
    tick(1);
    check_idle_outputs("reset");

    // 1: basic 4-beat packet, latency grant->tvalid
    send_pkt(3'd0, 2'd1, 4, 8'h0F);
    drain_pkt(0, "t1", fv);
    check("t1 latency", fv, 1);

    // 2: same packet under toggling tready
    send_pkt(3'd0, 2'd1, 4, 8'h0F);
    drain_pkt(1, "t2", fv);

    // 3: fill data FIFO, then a matching packet is refused
    for (int i = 0; i < 4; i++) send_pkt(3'd0, 2'd1, 64, 8'hFF);
    tick(5);
    check("t3 req_before", o_trans_req, 1'b1);
    send_pkt(3'd0, 2'd1, 3, 8'h07);
    tick(6);
    check("t3 drops", drop_seen, m_drops);
    check("t3 req_after", o_trans_req, 1'b1);
    for (int i = 0; i < 4; i++) drain_pkt(2, "t3", fv);

    // 4: oversize packet then a normal one
    send_pkt(3'd0, 2'd1, 70, 8'h3C);
    send_pkt(3'd0, 2'd1, 2, 8'h01);
    drain_pkt(2, "t4a", fv);
    drain_pkt(2, "t4b", fv);

    // 5: non-switchable traffic
    send_pkt(3'd0, 2'd0, 3, 8'h01);
    send_pkt(3'd5, 2'd1, 3, 8'h01);
    send_pkt(3'd1, 2'd2, 2, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_trans_req) seen = 1'b1;
      @(negedge i_clk);
    end
    check("t5 req", seen, 1'b0);
    check("t5 drops", drop_seen, m_drops);

`ifdef XBAR_PKT_STATS_EN
    check("stat_pkts mid", o_stat_pkts, m_stat_pkts);
    check("stat_drops mid", o_stat_drops, m_stat_drops);
`endif

    // 6: reset while egress presents beat 2
    send_pkt(3'd0, 2'd1, 4, 8'hFF);
    send_pkt(3'd0, 2'd1, 3, 8'h03);
    t = 0;
    while (!o_trans_req && t < 50) begin @(negedge i_clk); t++; end
    check("t6 req", o_trans_req, 1'b1);
    m_axis_tx_tready = 1'b1;
    i_trans_grant = 1'b1;
    @(negedge i_clk);
    i_trans_grant = 1'b0;
    t = 0;
    while (!m_axis_tx_tvalid && t < 20) begin @(negedge i_clk); t++; end
    check("t6 valid", m_axis_tx_tvalid, 1'b1);
    @(negedge i_clk);
    i_rst = 1'b1;
    m_axis_tx_tready = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    st_beats = 0;
    st_pkts = 0;
    m_stat_pkts = 0;
    m_stat_drops = 0;
    check_idle_outputs("t6 post_reset");
    tick(10);
    check("t6 no_stale_req", o_trans_req, 1'b0);
    check("t6 no_valid", m_axis_tx_tvalid, 1'b0);
    send_pkt(3'd0, 2'd1, 1, 8'h01);
    drain_pkt(0, "t6 fresh", fv);

    // randomized rounds: inject with egress stalled, then drain everything
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 8; p++) begin
        if ($urandom_range(0, 9) < 6) begin
          dst = 3'd0;
          usr = 2'd1;
        end else begin
          dst = 3'($urandom_range(0, 7));
          usr = 2'($urandom_range(0, 3));
        end
        send_pkt(dst, usr, $urandom_range(1, 70), 8'($urandom_range(1, 255)));
        tick($urandom_range(0, 2));
      end
      tick(6);
      check("rnd drops", drop_seen, m_drops);
      t = 0;
      while (st_pkts > 0 && t < 40) begin
        drain_pkt(2, "rnd", fv);
        t++;
      end
      tick(4);
      check("rnd idle_req", o_trans_req, 1'b0);
      check("rnd model_empty", exp_q.size(), 0);
    end

`ifdef XBAR_PKT_STATS_EN
    check("stat_pkts end", o_stat_pkts, m_stat_pkts);
    check("stat_drops end", o_stat_drops, m_stat_drops);
`else
    check("stat_pkts tied", o_stat_pkts, 32'h0);
    check("stat_drops tied", o_stat_drops, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
